// File: rtl/log_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : log_fp_pkg
// Description : Shared types, mode encodings and format helpers for the
//               byte-serial logarithmic / exact floating-point multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package log_fp_pkg;

    // Sequencer states of the serial wrapper
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Runtime multiply mode encodings
    localparam logic MODE_LOG   = 1'b0;
    localparam logic MODE_EXACT = 1'b1;

    // Total encoded width: sign + exponent + mantissa
    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Number of bytes needed to carry one encoded value
    function automatic int fp_nbytes(input int w);
        return (w + 7) / 8;
    endfunction

    // Canonical quiet NaN: positive, exponent all-ones, mantissa MSB set
    function automatic logic [63:0] fp_nan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    // Infinity with the requested sign
    function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        if (sign) begin
            r = r | (64'd1 << (exp_w + man_w));
        end
        return r;
    endfunction

    // Zero with the requested sign
    function automatic logic [63:0] fp_zero(input logic sign, input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        if (sign) begin
            r = r | (64'd1 << (exp_w + man_w));
        end
        return r;
    endfunction

endpackage : log_fp_pkg
`default_nettype wire

// File: rtl/log_fp_mul_core.sv
`default_nettype none
// ============================================================================
// Module      : log_fp_mul_core
// Description : Combinational FP multiply: field decode, special operands,
//               Mitchell and exact mantissa paths, exponent range and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module log_fp_mul_core
    import log_fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic [fp_width(EXP_W, MAN_W)-1:0] i_a,
    input  logic [fp_width(EXP_W, MAN_W)-1:0] i_b,
    input  logic                              i_mode,
    output logic [fp_width(EXP_W, MAN_W)-1:0] o_result,
    output logic                              o_ovf,
    output logic                              o_unf,
    output logic                              o_nan
);

    localparam int W  = fp_width(EXP_W, MAN_W);
    localparam int PW = 2*MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic [63:0]          c_NAN  = fp_nan(EXP_W, MAN_W);
    localparam logic [63:0]          c_INF  = fp_inf(1'b0, EXP_W, MAN_W);
    localparam logic [63:0]          c_ZERO = fp_zero(1'b0, EXP_W, MAN_W);
    localparam logic signed [EW-1:0] c_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] c_EMAX = EW'((2**EXP_W) - 1);

    logic               w_sa, w_sb, w_s;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_ma, w_mb;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [MAN_W:0]     w_sum;
    logic [PW-1:0]      w_prod;
    logic               w_carry;
    logic [MAN_W-1:0]   w_mout;
    logic signed [EW-1:0] w_exp;
    logic               w_exp_ovf, w_exp_unf;
    logic               w_unused_prod;

    // Field split
    assign w_sa = i_a[W-1];
    assign w_sb = i_b[W-1];
    assign w_ea = i_a[W-2 -: EXP_W];
    assign w_eb = i_b[W-2 -: EXP_W];
    assign w_ma = i_a[MAN_W-1:0];
    assign w_mb = i_b[MAN_W-1:0];
    assign w_s  = w_sa ^ w_sb;

    // Operand classification; denormals fall into the zero class
    assign w_a_nan  = (&w_ea) & (|w_ma);
    assign w_b_nan  = (&w_eb) & (|w_mb);
    assign w_a_inf  = (&w_ea) & ~(|w_ma);
    assign w_b_inf  = (&w_eb) & ~(|w_mb);
    assign w_a_zero = ~(|w_ea);
    assign w_b_zero = ~(|w_eb);

    // Mitchell path: log2(1+m) ~ m, so the product mantissa is a plain add
    assign w_sum = {1'b0, w_ma} + {1'b0, w_mb};

    // Exact path: full significand product, truncated after normalisation
    assign w_prod = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});
    assign w_unused_prod = ^w_prod[MAN_W-1:0];

    assign w_carry = (i_mode == MODE_LOG) ? w_sum[MAN_W] : w_prod[PW-1];
    assign w_mout  = (i_mode == MODE_LOG) ? w_sum[MAN_W-1:0]
                   : (w_prod[PW-1] ? w_prod[PW-2 -: MAN_W] : w_prod[PW-3 -: MAN_W]);

    // Biased exponent with two guard bits so both overflow and negatives are visible
    assign w_exp     = EW'(w_ea) + EW'(w_eb) - c_BIAS + EW'(w_carry);
    assign w_exp_ovf = (w_exp >= c_EMAX);
    assign w_exp_unf = w_exp[EW-1] | (w_exp == '0);

    // Result selection in priority order: NaN, infinity, zero operand, range
    always_comb begin
        o_result = {w_s, w_exp[EXP_W-1:0], w_mout};
        o_ovf    = 1'b0;
        o_unf    = 1'b0;
        o_nan    = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            o_result = c_NAN[W-1:0];
            o_nan    = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            o_result = {w_s, c_INF[W-2:0]};
        end else if (w_a_zero || w_b_zero) begin
            o_result = {w_s, c_ZERO[W-2:0]};
        end else if (w_exp_ovf) begin
            o_result = {w_s, c_INF[W-2:0]};
            o_ovf    = 1'b1;
        end else if (w_exp_unf) begin
            o_result = {w_s, c_ZERO[W-2:0]};
            o_unf    = 1'b1;
        end
    end

endmodule : log_fp_mul_core
`default_nettype wire

// File: rtl/log_fp_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : log_fp_mul_serial
// Description : Byte-serial wrapper around log_fp_mul_core. Collects A/B
//               LSB-first, computes in one cycle, streams the result back.
// Revision    : 1.0 - initial release
// ============================================================================
module log_fp_mul_serial
    import log_fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  logic       mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic       flag_ovf,
    output logic       flag_unf,
    output logic       flag_nan
);

    localparam int W      = fp_width(EXP_W, MAN_W);
    localparam int NBYTES = fp_nbytes(W);
    localparam int PADW   = NBYTES * 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NBYTES - 1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_a   [NBYTES];
    logic [7:0]       r_b   [NBYTES];
    logic [7:0]       r_res [NBYTES];
    logic             r_mode;
    logic             r_ovf, r_unf, r_nan;

    logic [PADW-1:0]  w_a_flat, w_b_flat, w_res_pad;
    logic [W-1:0]     w_core_res;
    logic             w_core_ovf, w_core_unf, w_core_nan;

    // Flatten the byte-wide operand stores into words for the core
    for (genvar k = 0; k < NBYTES; k++) begin : g_flat
        assign w_a_flat[8*k +: 8] = r_a[k];
        assign w_b_flat[8*k +: 8] = r_b[k];
    end

    // Bits above W in the top byte carry no meaning and are dropped
    if (PADW > W) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^{w_a_flat[PADW-1:W], w_b_flat[PADW-1:W]};
    end

    assign w_res_pad = PADW'(w_core_res);

    log_fp_mul_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .BIAS  (BIAS)
    ) u_core (
        .i_a      (w_a_flat[W-1:0]),
        .i_b      (w_b_flat[W-1:0]),
        .i_mode   (r_mode),
        .o_result (w_core_res),
        .o_ovf    (w_core_ovf),
        .o_unf    (w_core_unf),
        .o_nan    (w_core_nan)
    );

    assign flag_ovf = r_ovf;
    assign flag_unf = r_unf;
    assign flag_nan = r_nan;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = 8'h00;
        case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == c_LAST)) begin
                    w_next = COMPUTE;
                end
            end
            COMPUTE: begin
                w_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_byte  = r_res[r_cnt];
                out_last  = (r_cnt == c_LAST);
                if (out_ready && (r_cnt == c_LAST)) begin
                    w_next = COLLECT;
                end
            end
            default: begin
                w_next = COLLECT;
            end
        endcase
    end

    // Operand capture, byte counter, result and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_nan  <= 1'b0;
            for (int k = 0; k < NBYTES; k++) begin
                r_a[k]   <= 8'h00;
                r_b[k]   <= 8'h00;
                r_res[k] <= 8'h00;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        r_a[r_cnt] <= a_byte;
                        r_b[r_cnt] <= b_byte;
                        if (r_cnt == '0) begin
                            r_mode <= mode;
                        end
                        if (r_cnt == c_LAST) begin
                            r_cnt <= '0;
                            r_ovf <= 1'b0;
                            r_unf <= 1'b0;
                            r_nan <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    for (int k = 0; k < NBYTES; k++) begin
                        r_res[k] <= w_res_pad[8*k +: 8];
                    end
                    r_ovf <= w_core_ovf;
                    r_unf <= w_core_unf;
                    r_nan <= w_core_nan;
                end
                EMIT: begin
                    if (out_ready) begin
                        r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule : log_fp_mul_serial
`default_nettype wire

// File: tb/tb_log_fp_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_log_fp_mul_serial
// Description : Directed self-checking bench for log_fp_mul_serial (half
//               precision instance plus a bfloat16 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_log_fp_mul_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_byte, b_byte;
    logic       mode, out_ready;
    logic       hv, bv;
    logic       sel;

    logic       h_in_ready, h_out_valid, h_out_last, h_ovf, h_unf, h_nan;
    logic [7:0] h_out_byte;
    logic       f_in_ready, f_out_valid, f_out_last, f_ovf, f_unf, f_nan;
    logic [7:0] f_out_byte;

    logic       o_in_ready, o_out_valid, o_out_last;
    logic [7:0] o_out_byte;
    logic [2:0] o_flags;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    log_fp_mul_serial u_half (
        .clk (clk), .rst_n (rst_n), .in_valid (hv), .in_ready (h_in_ready),
        .a_byte (a_byte), .b_byte (b_byte), .mode (mode),
        .out_valid (h_out_valid), .out_ready (out_ready), .out_byte (h_out_byte),
        .out_last (h_out_last), .flag_ovf (h_ovf), .flag_unf (h_unf), .flag_nan (h_nan)
    );

    log_fp_mul_serial #(.EXP_W (8), .MAN_W (7)) u_bf16 (
        .clk (clk), .rst_n (rst_n), .in_valid (bv), .in_ready (f_in_ready),
        .a_byte (a_byte), .b_byte (b_byte), .mode (mode),
        .out_valid (f_out_valid), .out_ready (out_ready), .out_byte (f_out_byte),
        .out_last (f_out_last), .flag_ovf (f_ovf), .flag_unf (f_unf), .flag_nan (f_nan)
    );

    assign o_in_ready  = sel ? f_in_ready  : h_in_ready;
    assign o_out_valid = sel ? f_out_valid : h_out_valid;
    assign o_out_last  = sel ? f_out_last  : h_out_last;
    assign o_out_byte  = sel ? f_out_byte  : h_out_byte;
    assign o_flags     = sel ? {f_ovf, f_unf, f_nan} : {h_ovf, h_unf, h_nan};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        hv = v & ~sel;
        bv = v & sel;
    endtask

    // Shift A/B in LSB-first; mode is inverted on later beats to prove it is latched on beat 0
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m, input int maxgap);
        for (int k = 0; k < 2; k++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (g > 0) begin
                set_valid(1'b0);
                repeat (g) @(posedge clk);
                #1;
            end
            a_byte = a[8*k +: 8];
            b_byte = b[8*k +: 8];
            mode   = (k == 0) ? m : ~m;
            set_valid(1'b1);
            #1;
            check("in_ready_collect", 16'(o_in_ready), 16'h1);
            @(posedge clk);
            #1;
        end
        set_valid(1'b0);
    endtask

    // Expect COMPUTE, then two result bytes; optional stall on byte 0
    task automatic recv(input logic [15:0] exp, input logic [2:0] eflags, input int stall);
        @(negedge clk);
        check("compute_out_valid", 16'(o_out_valid), 16'h0);
        check("compute_in_ready",  16'(o_in_ready),  16'h0);
        out_ready = (stall == 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("out_valid", 16'(o_out_valid), 16'h1);
            check("out_byte",  16'(o_out_byte),  16'(exp[8*k +: 8]));
            check("out_last",  16'(o_out_last),  16'(k == 1));
            check("flags",     16'(o_flags),     16'(eflags));
            if (k == 0 && stall > 0) begin
                repeat (stall) begin
                    @(negedge clk);
                    check("stall_out_byte", 16'(o_out_byte),  16'(exp[7:0]));
                    check("stall_out_last", 16'(o_out_last),  16'h0);
                    check("stall_flags",    16'(o_flags),     16'(eflags));
                    check("stall_in_ready", 16'(o_in_ready),  16'h0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("done_out_valid", 16'(o_out_valid), 16'h0);
        check("done_in_ready",  16'(o_in_ready),  16'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  16'(o_in_ready),  16'h1);
        check({tag, "_out_valid"}, 16'(o_out_valid), 16'h0);
        check({tag, "_out_byte"},  16'(o_out_byte),  16'h0);
        check({tag, "_out_last"},  16'(o_out_last),  16'h0);
        check({tag, "_flags"},     16'(o_flags),     16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; a_byte = 8'h00; b_byte = 8'h00; mode = 1'b0;
        out_ready = 1'b1; hv = 1'b0; bv = 1'b0; sel = 1'b0;
        #23;
        sel = 1'b0; #1; check_reset_outputs("reset_half");
        sel = 1'b1; #1; check_reset_outputs("reset_bf16");
        sel = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Flags are {ovf, unf, nan}
        send(16'h3E00, 16'h3E00, 1'b0, 0); recv(16'h4000, 3'b000, 0);
        send(16'h3E00, 16'h3E00, 1'b1, 0); recv(16'h4080, 3'b000, 0);
        send(16'hBC00, 16'h3C00, 1'b1, 0); recv(16'hBC00, 3'b000, 0);
        send(16'h7BFF, 16'h7BFF, 1'b0, 0); recv(16'h7C00, 3'b100, 0);
        send(16'h7BFF, 16'h7BFF, 1'b1, 0); recv(16'h7C00, 3'b100, 0);
        send(16'hFBFF, 16'h7BFF, 1'b0, 0); recv(16'hFC00, 3'b100, 0);
        send(16'h0400, 16'h0400, 1'b0, 0); recv(16'h0000, 3'b010, 0);
        send(16'h7C00, 16'h0000, 1'b0, 0); recv(16'h7E00, 3'b001, 0);
        send(16'hFC00, 16'h4000, 1'b1, 0); recv(16'hFC00, 3'b000, 0);
        send(16'h0001, 16'h4000, 1'b0, 0); recv(16'h0000, 3'b000, 0);
        send(16'h7E01, 16'h3C00, 1'b1, 0); recv(16'h7E00, 3'b001, 0);
        send(16'h8000, 16'h3C00, 1'b0, 0); recv(16'h8000, 3'b000, 0);

        // Backpressure on the first result byte
        send(16'h3E00, 16'h3E00, 1'b1, 0); recv(16'h4080, 3'b000, 5);
        send(16'h7BFF, 16'h7BFF, 1'b1, 0); recv(16'h7C00, 3'b100, 5);

        // Gapped input beats
        send(16'h3E00, 16'h3E00, 1'b0, 3); recv(16'h4000, 3'b000, 0);
        send(16'h0400, 16'h0400, 1'b1, 3); recv(16'h0000, 3'b010, 0);

        // Reset after one accepted byte discards the partial operand
        a_byte = 8'hAA; b_byte = 8'h55; mode = 1'b1;
        set_valid(1'b1);
        @(posedge clk); #1;
        set_valid(1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        send(16'h3C00, 16'h4000, 1'b0, 0); recv(16'h4000, 3'b000, 0);

        // bfloat16 instance, exact mode: 1.5 x 2.0 = 3.0
        sel = 1'b1;
        #1;
        send(16'h3FC0, 16'h4000, 1'b1, 0); recv(16'h4040, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_log_fp_mul_serial
`default_nettype wire
